// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: branch opcodes,
// 2-bit predictor counter encodings and the default reset PC.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic is_cond_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BGTZ);
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// 16-entry table of 2-bit saturating direction counters. Reads are
// combinational, so a same-cycle update to the read index returns the old value.
module branch_history_table
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rd_index,
  output logic       rd_taken,
  input  logic       upd_valid,
  input  logic [3:0] upd_index,
  input  logic       upd_taken
);

  logic [1:0] ctr [16];

  assign rd_taken = ctr[rd_index][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ctr[i] <= WNT;
    end else if (upd_valid) begin
      if (upd_taken && (ctr[upd_index] != ST)) begin
        ctr[upd_index] <= ctr[upd_index] + 2'd1;
      end else if (!upd_taken && (ctr[upd_index] != SNT)) begin
        ctr[upd_index] <= ctr[upd_index] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// branch counters. Define FETCH_BHT_EN for a local dynamic direction predictor.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic [31:0]      PC,
  input  logic [31:0]      Instr,
  input  logic             branch_taken,
  input  logic [31:0]      PC_Predict,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             ex_branch_valid,
  input  logic             ex_branch_outcome,
  input  logic             ex_branch_predicted,
  input  logic [31:0]      ex_branch_pc,
  input  logic [31:0]      ex_branch_target,
  output logic [31:0]      FD_Instr,
  output logic [31:0]      FD_PCPlus4,
  output logic             FD_Predicted,
  output logic             FD_Valid,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        fd_flush;

  assign pc_plus4   = PC + 32'd4;
  assign mispredict = rst_n & ex_branch_valid & (ex_branch_outcome != ex_branch_predicted);
  // A jump seen during a stall is dropped here; ID presents it again afterwards.
  assign fd_flush   = mispredict | (jump & ~stall);

`ifdef FETCH_BHT_EN
  logic bht_taken;
  logic unused_static_pred;

  assign unused_static_pred = ^{branch_taken, PC_Predict};

  branch_history_table u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_index  (PC[5:2]),
    .rd_taken  (bht_taken),
    .upd_valid (ex_branch_valid),
    .upd_index (ex_branch_pc[5:2]),
    .upd_taken (ex_branch_outcome)
  );

  assign pred_taken  = is_cond_branch(Instr[31:26]) & bht_taken;
  assign pred_target = pc_plus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00};
`else
  assign pred_taken  = branch_taken;
  assign pred_target = PC_Predict;
`endif

  always_comb begin
    next_pc = pc_plus4;
    if (mispredict) begin
      next_pc = ex_branch_outcome ? ex_branch_target : (ex_branch_pc + 32'd4);
    end else if (stall) begin
      next_pc = PC;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (pred_taken) begin
      next_pc = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) PC <= RESET_PC;
    else        PC <= next_pc;
  end

  // The flush test comes before the stall test so a stalled wrong-path slot is squashed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      FD_Instr     <= 32'd0;
      FD_PCPlus4   <= 32'd0;
      FD_Predicted <= 1'b0;
      FD_Valid     <= 1'b0;
    end else if (fd_flush) begin
      FD_Instr     <= 32'd0;
      FD_Predicted <= 1'b0;
      FD_Valid     <= 1'b0;
    end else if (!stall) begin
      FD_Instr     <= Instr;
      FD_PCPlus4   <= pc_plus4;
      FD_Predicted <= pred_taken;
      FD_Valid     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_branch_valid && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked against a cycle-level architectural model of the fetch stage.
module tb_fetch_unit;

  localparam int          CNT_W = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic [31:0]      PC;
  logic [31:0]      Instr;
  logic             branch_taken;
  logic [31:0]      PC_Predict;
  logic             jump;
  logic [31:0]      jump_target;
  logic             ex_branch_valid;
  logic             ex_branch_outcome;
  logic             ex_branch_predicted;
  logic [31:0]      ex_branch_pc;
  logic [31:0]      ex_branch_target;
  logic [31:0]      FD_Instr;
  logic [31:0]      FD_PCPlus4;
  logic             FD_Predicted;
  logic             FD_Valid;
  logic             mispredict;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  // Instruction memory stand-in: every word is a hash of its address.
  logic [31:0] salt;
  logic        pt_en;

  function automatic logic [31:0] imem_word(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B9) ^ s;
  endfunction

  assign Instr        = imem_word(PC, salt);
  assign branch_taken = pt_en & (Instr[1:0] == 2'b00);
  assign PC_Predict   = {16'h0000, Instr[15:2], 2'b00};

  fetch_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .stall               (stall),
    .PC                  (PC),
    .Instr               (Instr),
    .branch_taken        (branch_taken),
    .PC_Predict          (PC_Predict),
    .jump                (jump),
    .jump_target         (jump_target),
    .ex_branch_valid     (ex_branch_valid),
    .ex_branch_outcome   (ex_branch_outcome),
    .ex_branch_predicted (ex_branch_predicted),
    .ex_branch_pc        (ex_branch_pc),
    .ex_branch_target    (ex_branch_target),
    .FD_Instr            (FD_Instr),
    .FD_PCPlus4          (FD_PCPlus4),
    .FD_Predicted        (FD_Predicted),
    .FD_Valid            (FD_Valid),
    .mispredict          (mispredict),
    .branch_cnt          (branch_cnt),
    .mispredict_cnt      (mispredict_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_fd_instr;
  logic [31:0] m_fd_pc4;
  logic        m_fd_pred;
  logic        m_fd_valid;
  int          m_bcnt;
  int          m_mcnt;
  int          m_bht [16];

  function automatic logic [31:0] model_pred_target(input logic [31:0] pc);
    logic [31:0] ins;
    logic signed [31:0] off;
    ins = imem_word(pc, salt);
`ifdef FETCH_BHT_EN
    off = $signed(ins[15:0]);
    return pc + 32'd4 + 32'(off * 4);
`else
    off = 0;
    return {16'h0000, ins[15:2], 2'b00} + 32'(off);
`endif
  endfunction

  function automatic logic model_pred_taken(input logic [31:0] pc);
    logic [31:0] ins;
    int op;
    ins = imem_word(pc, salt);
    op  = int'(ins[31:26]);
`ifdef FETCH_BHT_EN
    return (op == 4 || op == 5 || op == 7) && (m_bht[int'(pc[5:2])] >= 2);
`else
    return pt_en && (ins[1:0] == 2'b00) && (op >= 0);
`endif
  endfunction

  task automatic model_reset();
    m_pc       = RST_PC;
    m_fd_instr = 32'd0;
    m_fd_pc4   = 32'd0;
    m_fd_pred  = 1'b0;
    m_fd_valid = 1'b0;
    m_bcnt     = 0;
    m_mcnt     = 0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic wrong;
    logic taken;
    logic [31:0] tgt;
    int idx;
    if (!rst_n) begin
      model_reset();
    end else begin
      wrong = ex_branch_valid && (ex_branch_outcome != ex_branch_predicted);
      taken = model_pred_taken(m_pc);
      tgt   = model_pred_target(m_pc);
      if (ex_branch_valid) m_bcnt = (m_bcnt < CNT_MAX) ? m_bcnt + 1 : CNT_MAX;
      if (wrong)           m_mcnt = (m_mcnt < CNT_MAX) ? m_mcnt + 1 : CNT_MAX;
      if (ex_branch_valid) begin
        idx = int'(ex_branch_pc[5:2]);
        if (ex_branch_outcome) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
        else                   m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
      end
      if (wrong || (jump && !stall)) begin
        m_fd_instr = 32'd0;
        m_fd_pred  = 1'b0;
        m_fd_valid = 1'b0;
      end else if (!stall) begin
        m_fd_instr = imem_word(m_pc, salt);
        m_fd_pc4   = m_pc + 32'd4;
        m_fd_pred  = taken;
        m_fd_valid = 1'b1;
      end
      if (wrong)       m_pc = ex_branch_outcome ? ex_branch_target : ex_branch_pc + 32'd4;
      else if (stall)  m_pc = m_pc;
      else if (jump)   m_pc = jump_target;
      else if (taken)  m_pc = tgt;
      else             m_pc = m_pc + 32'd4;
    end
    exp_q.push_back(m_pc);
  endtask

  // Drivers
  task automatic drive(input logic s, input logic j, input logic [31:0] jt,
                       input logic v, input logic o, input logic p,
                       input logic [31:0] bpc, input logic [31:0] bt);
    stall               = s;
    jump                = j;
    jump_target         = jt;
    ex_branch_valid     = v;
    ex_branch_outcome   = o;
    ex_branch_predicted = p;
    ex_branch_pc        = bpc;
    ex_branch_target    = bt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // One cycle: compare DUT against the model at the falling edge, then advance.
  task automatic run_cycle();
    logic e_mp;
    logic [31:0] e_pc;
    @(negedge clk);
    e_mp = rst_n && ex_branch_valid && (ex_branch_outcome != ex_branch_predicted);
    e_pc = (exp_q.size() != 0) ? exp_q.pop_front() : m_pc;
    check("pc", PC, e_pc);
    check("fd_valid", FD_Valid, m_fd_valid);
    check("fd_instr", FD_Instr, m_fd_instr);
    check("fd_predicted", FD_Predicted, m_fd_pred);
    if (m_fd_valid) check("fd_pcplus4", FD_PCPlus4, m_fd_pc4);
    check("mispredict", mispredict, e_mp);
    check("branch_cnt", branch_cnt, m_bcnt);
    check("mispredict_cnt", mispredict_cnt, m_mcnt);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    salt        = 32'h1234_5678;
    pt_en       = 1'b0;
    rst_n       = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    exp_q.push_back(m_pc);

    // Reset state, including the IF/ID PC+4 field
    run_cycle();
    check("reset_fd_pcplus4", FD_PCPlus4, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch 0, 4, 8, C
    repeat (4) run_cycle();

    // Stall for three cycles at 0x10
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) run_cycle();
    idle();
    repeat (5) run_cycle();

    // Jump to 0x40 decoded while PC=0x24
    drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();
    idle();
    repeat (2) run_cycle();

    // Backward beq at 0x30 predicted taken, resolves not-taken
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h20);
    run_cycle();
    idle();
    run_cycle();

    // Mispredict together with stall: redirect wins
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h60, 32'h80);
    run_cycle();
    // Stall together with jump: jump ignored
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) run_cycle();
    idle();
    run_cycle();

    // PC wrap through 32'hFFFF_FFFC, then a not-taken redirect that also wraps
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_cycle();
    idle();
    repeat (3) run_cycle();
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h100);
    run_cycle();
    idle();
    run_cycle();

    // Static predictions active
    pt_en = 1'b1;
    repeat (12) run_cycle();

    // Random traffic, with occasional mid-run resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0) salt = $urandom();
      pt_en = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      drive(($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0),
            {$urandom_range(0, 255), 2'b00},
            ($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            {$urandom(), 2'b00} | ((n % 7 == 0) ? 32'hFFFF_FFFC : 32'h0),
            {$urandom_range(0, 1023), 2'b00});
      run_cycle();
    end

    rst_n = 1'b1;
    idle();
    repeat (4) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the memory controller. It owns the PC register, drives the instruction-memory address, and picks the next PC from redirect, jump, prediction or sequential sources. It captures fetched instructions into the IF/ID register and counts resolved and mispredicted branches.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- CNT_W, 16, width of the performance counters
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  from the hazard unit; holds PC and IF/ID
- PC  out  32  fetch address sent to the memory controller
- Instr  in  32  instruction for the current PC, combinational from the memory controller
- branch_taken  in  1  static prediction for Instr
- PC_Predict  in  32  predicted target for Instr
- jump  in  1  J-type decoded in ID
- jump_target  in  32  jump destination
- ex_branch_valid  in  1  a branch resolves in EX this cycle
- ex_branch_outcome  in  1  actual direction of that branch
- ex_branch_predicted  in  1  prediction carried with that branch
- ex_branch_pc  in  32  PC of that branch
- ex_branch_target  in  32  taken target of that branch
- FD_Instr  out  32  IF/ID instruction
- FD_PCPlus4  out  32  IF/ID PC+4
- FD_Predicted  out  1  the IF/ID instruction was predicted taken
- FD_Valid  out  1  IF/ID holds a live instruction
- mispredict  out  1  combinational flush request to ID/EX
- branch_cnt  out  CNT_W  branches resolved
- mispredict_cnt  out  CNT_W  mispredictions

## Operation
- mispredict = rst_n & ex_branch_valid & (ex_branch_outcome != ex_branch_predicted)
- Next-PC priority is fixed, highest first:
  - reset: RESET_PC
  - mispredict: if ex_branch_outcome, ex_branch_target; otherwise ex_branch_pc+4
  - stall: hold PC
  - jump: jump_target
  - predicted taken: PC_Predict
  - otherwise: PC+4
- IF/ID register:
  - flush (FD_Valid=0, FD_Instr=0, FD_Predicted=0) on mispredict or on jump without stall
  - hold on stall
  - otherwise load Instr, PC+4 and the prediction bit, with FD_Valid=1
- Mispredict overrides stall, so a stalled wrong-path instruction is still flushed.
- Jump during stall is ignored; ID re-presents the jump after the stall.
- PC adds are modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- Counters:
  - branch_cnt increments on ex_branch_valid; mispredict_cnt increments on mispredict.
  - Both saturate at all-ones and update regardless of stall.
- Reset values: PC=RESET_PC; FD_Instr, FD_PCPlus4, FD_Predicted, FD_Valid, both counters = 0. mispredict reads 0 while rst_n is low.
- Reset asserted mid-operation overrides every other event on that edge.

## Timing
- PC is a register. Instr, branch_taken and PC_Predict are same-cycle combinational returns for PC.
- Sequential fetch delivers one instruction per cycle.
- Jump seen in ID in cycle n: PC=jump_target at n+1; one bubble.
- Mispredict in EX in cycle n: corrected PC at n+1; IF/ID and ID/EX both squashed; two bubbles.
- A correct prediction costs zero bubbles.

## Configuration
- FETCH_BHT_EN defined:
  - Adds a 16-entry table of 2-bit saturating counters, indexed by PC[5:2].
  - Reset value of every entry is 2'b01.
  - For opcodes 000100, 000101 and 000111, the prediction is counter[1].
  - The target is computed locally as PC+4+(sign-extended imm<<2).
  - branch_taken and PC_Predict are ignored.
  - Update on ex_branch_valid at index ex_branch_pc[5:2]: +1 if taken, −1 if not, saturating at 0 and 3.
  - A same-cycle read and write to one index returns the old value.
- FETCH_BHT_EN undefined: the static branch_taken/PC_Predict inputs are used unchanged; no table is instantiated.

## Structure
- Shared package fetch_pkg holds:
  - opcode constants OP_BEQ, OP_BNE, OP_BGTZ
  - 2-bit counter encodings SNT, WNT, WT, ST
  - default RESET_PC
- Sub-module branch_history_table contains the table, its read port and its update logic. It is instantiated only under FETCH_BHT_EN.

## Test plan
- Reset, then release with sequential code → PC follows 0, 4, 8, C; FD_Valid=1 from the second cycle; counters stay 0.
- stall held 3 cycles at PC=0x10 → PC and FD frozen at 0x10/0x0C contents; fetch resumes at 0x14.
- jump to 0x40 decoded with PC=0x24 → next PC=0x40; FD_Valid=0 for one cycle.
- Backward beq at 0x30 (predicted taken, target 0x20) resolves not-taken → mispredict=1, next PC=0x34, IF/ID flushed, mispredict_cnt=1, branch_cnt=1.
- Mispredict and stall asserted together → redirect wins; stall and jump together → jump ignored.
- FETCH_BHT_EN build: forward branch at 0x08 resolves taken twice → entry 2 moves 01→10→11; the third fetch predicts taken with target PC+4+(imm<<2).
